sap_cpu_core: RTL and testbench
===============================

# sap_cpu_core

Parametrised successor to the team's fixed 8-bit bus CPU. It is a single-clock accumulator machine with a width-generic datapath: DATA_W-bit data and 2^ADDR_W words of internal register-file RAM. Internal transfers use a multiplexed datapath instead of a tri-state bus. Added over the previous generation: a flow-controlled program loader, conditional jumps, a store instruction and a one-cycle output strobe. It sits directly under the Tiny Tapeout top wrapper, which maps its ports onto ui/uo/uio pins.

## Interface
- DATA_W, 8, data/instruction word width; must satisfy DATA_W >= 4 + ADDR_W.
- ADDR_W, 4, address width; RAM depth and PC range are 2^ADDR_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clear  input  1  reset, asynchronous, active-high.
- prog  input  1  programming request.
- prog_valid  input  1  prog_data word valid.
- prog_data  input  DATA_W  program/data word to store.
- prog_ready  output  1  loader accepting words.
- done_load  output  1  all 2^ADDR_W words loaded.
- out_data  output  DATA_W  output register.
- out_valid  output  1  one-cycle pulse when out_data is updated by OUT.
- cf  output  1  carry flag.
- zf  output  1  zero flag.
- halted  output  1  HLT executed.

## Operation
- Instruction word: opcode = word[DATA_W-1:DATA_W-4]; operand = word[ADDR_W-1:0]; the middle bits are ignored.
- Opcodes:
  - 0 NOP.
  - 1 LDA: A<=M[op].
  - 2 ADD: A<=A+M[op].
  - 3 SUB: A<=A-M[op].
  - 4 STA: M[op]<=A.
  - 5 LDI: A<=zero-extended op.
  - 6 JMP: PC<=op.
  - 7 JC: jump if cf.
  - 8 JZ: jump if zf.
  - E OUT: out_data<=A, out_valid=1.
  - F HLT.
  - All other opcodes execute as NOP.
- Arithmetic is modulo 2^DATA_W. ADD: cf = carry-out. SUB: computed as A+~M+1, so cf=1 when A>=M (no borrow). zf = (result==0). Flags change only on ADD/SUB.
- RAM: flop array with combinational read and synchronous write. It is not cleared by clear.
- FSM states:
  - IDLE: if prog, go to LOAD with ld_addr=0; else go to FETCH.
  - LOAD: prog_ready=1. On prog_valid: M[ld_addr]<=prog_data and ld_addr++. After writing address 2^ADDR_W-1, go to DONE. If prog falls, go to FETCH; done_load stays 0 and unwritten words keep their old contents.
  - DONE: done_load=1. When prog=0, go to FETCH.
  - FETCH: IR<=M[PC], PC<=PC+1 (wraps to 0 after 2^ADDR_W-1); next state EXEC.
  - EXEC: perform IR; next state FETCH, or HALT for HLT.
  - HALT: halted=1. prog=1 goes to LOAD; otherwise stay in HALT.
- Entering FETCH from DONE, LOAD abort or IDLE always sets PC=0. A, flags and out_data are preserved.
- done_load clears on entry to LOAD.

## Timing
- clear asserted: state=IDLE; PC, IR, A, ld_addr, out_data = 0; cf, zf, halted, done_load, prog_ready, out_valid = 0. These values take effect immediately, without waiting for a clock edge.
- Clear mid-load or mid-instruction discards all progress. RAM words already written are kept.
- Every instruction takes exactly 2 cycles (FETCH, EXEC).
  - Results from EXEC are visible on the next cycle.
  - out_valid is high in the cycle after the OUT EXEC edge, for exactly one cycle.
  - halted rises in the cycle after HLT's EXEC.
- Jump target is fetched in the immediately following FETCH; there is no delay slot.
- Loader: one word per cycle max. A word is accepted on an edge where prog_ready && prog_valid. prog_ready falls in the cycle after the last word is accepted.
- prog going high during FETCH/EXEC is ignored; it is honoured only in IDLE and HALT.
- STA followed by LDA of the same address returns the new value (write completes at the EXEC edge).

## Configuration
- SAP_CPU_COND_JUMP_EN defined: JC and JZ are implemented as above.
- SAP_CPU_COND_JUMP_EN undefined: opcodes 7 and 8 execute as NOP; no flag-to-PC path is synthesised. cf and zf are still computed and output.

## Test plan
- Load [0x1E,0x2F,0xE0,0xF0,0…,0x05,0x07] (LDA 14, ADD 15, OUT, HLT; M[14]=5, M[15]=7) -> done_load=1 after 16 accepts; out_valid pulses once with out_data=12; halted rises 8 cycles after leaving DONE; cf=0, zf=0.
- ADD overflow: A=0xFF, M=0x01 -> A=0x00, cf=1, zf=1. SUB: A=3, M=5 -> A=0xFE, cf=0, zf=0.
- JZ loop: LDI 3; SUB of 1 in a loop until zero, OUT each pass -> out_data sequence 2,1,0 then HLT.
  - With the macro undefined, JZ falls through, so the sequence differs as predicted.
- Loader flow control: toggle prog_valid randomly; drop prog after 5 accepts -> only M[0..4] updated, done_load=0, execution starts at PC=0.
- Assert clear during EXEC of ADD and again during LOAD -> all outputs 0 immediately; RAM contents retained; reprogram succeeds.
- PC wrap: NOP at address 15 with no HLT -> next fetch from address 0.

Source files
------------

// File: rtl/sap_cpu_core.sv
// sap_cpu_core: width-generic accumulator CPU with a flow-controlled program loader.
// Optional feature macro: SAP_CPU_COND_JUMP_EN (JC/JZ implemented; otherwise they execute as NOP).
module sap_cpu_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              prog,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              done_load,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              cf,
  output logic              zf,
  output logic              halted
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DONE, S_FETCH, S_EXEC, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
    OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
  } opcode_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [3:0]          ir_op_q, ir_op_d;
  logic [ADDR_W-1:0]   ir_arg_q, ir_arg_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                cf_q, cf_d;
  logic                zf_q, zf_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   mem_rdata;
  logic [DATA_W:0]     sum_add;
  logic [DATA_W:0]     sum_sub;

  assign mem_rdata = mem_q[ir_arg_q];
  assign sum_add   = {1'b0, a_q} + {1'b0, mem_rdata};
  // Subtract as A + ~M + 1 so the carry-out reads as "no borrow".
  assign sum_sub   = {1'b0, a_q} + {1'b0, ~mem_rdata} + (DATA_W+1)'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_op_d     = ir_op_q;
    ir_arg_d    = ir_arg_q;
    a_d         = a_q;
    ld_addr_d   = ld_addr_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    cf_d        = cf_q;
    zf_d        = zf_q;
    done_d      = done_q;
    mem_we      = 1'b0;
    mem_waddr   = ld_addr_q;
    mem_wdata   = prog_data;

    unique case (state_q)
      S_IDLE: begin
        if (prog) begin
          state_d   = S_LOAD;
          ld_addr_d = '0;
          done_d    = 1'b0;
        end else begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_LOAD: begin
        if (prog_valid) begin
          mem_we    = 1'b1;
          ld_addr_d = ld_addr_q + ADDR_W'(1);
        end
        if (prog_valid && (ld_addr_q == '1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (!prog) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_DONE: begin
        if (!prog) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        ir_op_d  = mem_q[pc_q][DATA_W-1 -: 4];
        ir_arg_d = mem_q[pc_q][ADDR_W-1:0];
        pc_d     = pc_q + ADDR_W'(1);
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_op_q)
          OP_LDA: a_d = mem_rdata;
          OP_ADD: begin
            a_d  = sum_add[DATA_W-1:0];
            cf_d = sum_add[DATA_W];
            zf_d = (sum_add[DATA_W-1:0] == '0);
          end
          OP_SUB: begin
            a_d  = sum_sub[DATA_W-1:0];
            cf_d = sum_sub[DATA_W];
            zf_d = (sum_sub[DATA_W-1:0] == '0);
          end
          OP_STA: begin
            mem_we    = 1'b1;
            mem_waddr = ir_arg_q;
            mem_wdata = a_q;
          end
          OP_LDI: a_d = DATA_W'(ir_arg_q);
          OP_JMP: pc_d = ir_arg_q;
`ifdef SAP_CPU_COND_JUMP_EN
          OP_JC:  if (cf_q) pc_d = ir_arg_q;
          OP_JZ:  if (zf_q) pc_d = ir_arg_q;
`endif
          OP_OUT: begin
            out_d       = a_q;
            out_valid_d = 1'b1;
          end
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_HALT: begin
        if (prog) begin
          state_d   = S_LOAD;
          ld_addr_d = '0;
          done_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_op_q     <= '0;
      ir_arg_q    <= '0;
      a_q         <= '0;
      ld_addr_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cf_q        <= 1'b0;
      zf_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_op_q     <= ir_op_d;
      ir_arg_q    <= ir_arg_d;
      a_q         <= a_d;
      ld_addr_q   <= ld_addr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cf_q        <= cf_d;
      zf_q        <= zf_d;
      done_q      <= done_d;
    end
  end

  // RAM contents deliberately survive clear.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign prog_ready = (state_q == S_LOAD);
  assign halted     = (state_q == S_HALT);
  assign done_load  = done_q;
  assign out_data   = out_q;
  assign out_valid  = out_valid_q;
  assign cf         = cf_q;
  assign zf         = zf_q;
endmodule

// File: tb/tb_sap_cpu_core.sv
// Self-checking bench for sap_cpu_core: directed programs plus random programs,
// checked against an instruction-level reference model.
module tb_sap_cpu_core;
  logic       clk = 1'b0;
  logic       clear;
  logic       prog;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready;
  logic       done_load;
  logic [7:0] out_data;
  logic       out_valid;
  logic       cf;
  logic       zf;
  logic       halted;

  sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .clear      (clear),
    .prog       (prog),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .done_load  (done_load),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .cf         (cf),
    .zf         (zf),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0] pw [16];
  logic [7:0] mm [16];
  logic [7:0] ma, mout;
  logic       mcf, mzf;
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  bit         last_halted = 1'b0;

  always @(negedge clk) if (out_valid) got_q.push_back(out_data);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    #1;
    check({tag, ".clr.ready"}, prog_ready, 0);
    check({tag, ".clr.done"},  done_load,  0);
    check({tag, ".clr.out"},   out_data,   0);
    check({tag, ".clr.ovld"},  out_valid,  0);
    check({tag, ".clr.cf"},    cf,         0);
    check({tag, ".clr.zf"},    zf,         0);
    check({tag, ".clr.halt"},  halted,     0);
    ma = '0; mout = '0; mcf = 1'b0; mzf = 1'b0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Instruction-level model: runs up to max_steps instructions from PC 0.
  task automatic model_run(input int unsigned max_steps, output int unsigned steps, output bit hlt);
    logic [3:0] pc;
    logic [7:0] w, m;
    int         s;
    pc = 4'd0; steps = 0; hlt = 1'b0;
    exp_q.delete();
    while (steps < max_steps && !hlt) begin
      w = mm[pc];
      pc = pc + 4'd1;
      steps++;
      m = mm[w[3:0]];
      case (w[7:4])
        4'h1: ma = m;
        4'h2: begin s = int'(ma) + int'(m); mcf = (s > 255); ma = 8'(s); mzf = (ma == 0); end
        4'h3: begin mcf = (ma >= m); ma = ma - m; mzf = (ma == 0); end
        4'h4: mm[w[3:0]] = ma;
        4'h5: ma = {4'h0, w[3:0]};
        4'h6: pc = w[3:0];
`ifdef SAP_CPU_COND_JUMP_EN
        4'h7: if (mcf) pc = w[3:0];
        4'h8: if (mzf) pc = w[3:0];
`endif
        4'hE: begin mout = ma; exp_q.push_back(ma); end
        4'hF: hlt = 1'b1;
        default: ;
      endcase
    end
  endtask

  // Called at a negedge with the DUT in IDLE or HALT.
  task automatic do_load(input int unsigned n, input bit by_clear, input string tag);
    int unsigned k = 0;
    int unsigned guard = 0;
    prog = 1'b1; prog_valid = 1'b0;
    @(negedge clk);
    check({tag, ".ld.ready"}, prog_ready, 1);
    check({tag, ".ld.done0"}, done_load, 0);
    while (k < n && guard < 400) begin
      prog_valid = ($urandom_range(0, 2) != 0);
      prog_data  = pw[k];
      @(negedge clk);
      if (prog_valid) begin
        mm[k] = pw[k];
        k++;
      end
      guard++;
    end
    prog_valid = 1'b0;
    check({tag, ".ld.accepts"}, k, n);
    if (by_clear) begin
      do_clear({tag, ".midload"});
    end else if (n == 16) begin
      check({tag, ".ld.ready_fell"}, prog_ready, 0);
      check({tag, ".ld.done1"}, done_load, 1);
    end else begin
      check({tag, ".ld.still_ready"}, prog_ready, 1);
      check({tag, ".ld.done_abort"}, done_load, 0);
    end
  endtask

  // Called at a negedge; the next rising edge leaves DONE/LOAD/IDLE into FETCH.
  task automatic dut_run(input int unsigned budget, input string tag);
    int unsigned steps;
    bit hlt;
    model_run(budget, steps, hlt);
    got_q.delete();
    prog = 1'b0; prog_valid = 1'b0;
    if (hlt) begin
      repeat (2 * steps) @(posedge clk);
      @(negedge clk);
      check({tag, ".pre_halt"}, halted, 0);
      @(posedge clk);
      @(negedge clk);
      check({tag, ".halted"}, halted, 1);
    end else begin
      repeat (2 * steps + 1) @(posedge clk);
      @(negedge clk);
      check({tag, ".running"}, halted, 0);
    end
    check({tag, ".cf"}, cf, mcf);
    check({tag, ".zf"}, zf, mzf);
    check({tag, ".out_data"}, out_data, mout);
    @(negedge clk);
    check({tag, ".n_out"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s.out[%0d]", tag, i), got_q[i], exp_q[i]);
    last_halted = hlt;
  endtask

  task automatic start_load(input string tag);
    if (!last_halted) begin
      prog = 1'b1;
      do_clear(tag);
    end
  endtask

  task automatic set_prog(input logic [7:0] w0, w1, w2, w3, w4, w5, m14, m15);
    for (int i = 0; i < 16; i++) pw[i] = 8'h00;
    pw[0] = w0; pw[1] = w1; pw[2] = w2; pw[3] = w3; pw[4] = w4; pw[5] = w5;
    pw[14] = m14; pw[15] = m15;
  endtask

  initial begin
    prog = 1'b1; prog_valid = 1'b0; prog_data = '0; clear = 1'b0;
    do_clear("reset");

    set_prog(8'h1E, 8'h2F, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h05, 8'h07);
    do_load(16, 1'b0, "plan");
    dut_run(40, "plan");
    check("plan.out12", out_data, 8'd12);
    check("plan.done_kept", done_load, 1);

    set_prog(8'h1E, 8'h2F, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'hFF, 8'h01);
    start_load("ovf");
    do_load(16, 1'b0, "ovf");
    dut_run(40, "ovf");
    check("ovf.a", out_data, 8'h00);
    check("ovf.cf1", cf, 1);
    check("ovf.zf1", zf, 1);

    set_prog(8'h53, 8'h3F, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h05);
    start_load("sub");
    do_load(16, 1'b0, "sub");
    dut_run(40, "sub");
    check("sub.a", out_data, 8'hFE);
    check("sub.cf0", cf, 0);

    set_prog(8'h53, 8'h3F, 8'hE0, 8'h85, 8'h61, 8'hF0, 8'h00, 8'h01);
    start_load("jz");
    do_load(16, 1'b0, "jz");
    dut_run(40, "jz");

    set_prog(8'h1E, 8'h2F, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h30, 8'h40);
    start_load("clr_exec");
    do_load(16, 1'b0, "clr_exec");
    prog = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    do_clear("clr_exec");
    dut_run(40, "clr_exec");
    check("clr_exec.sum", out_data, 8'h70);

    for (int i = 0; i < 16; i++) pw[i] = 8'($urandom);
    start_load("clr_load");
    do_load(7, 1'b1, "clr_load");
    set_prog(8'h1E, 8'h2F, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h05, 8'h07);
    do_load(16, 1'b0, "reload");
    dut_run(40, "reload");

    for (int i = 0; i < 16; i++) pw[i] = 8'($urandom);
    start_load("abort");
    do_load(5, 1'b0, "abort");
    dut_run(30, "abort");
    check("abort.done0", done_load, 0);

    set_prog(8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h59, 8'h00);
    start_load("wrap");
    do_load(16, 1'b0, "wrap");
    dut_run(17, "wrap");

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) pw[i] = 8'($urandom);
      start_load($sformatf("rnd%0d", t));
      do_load(16, 1'b0, $sformatf("rnd%0d", t));
      dut_run(30, $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end
endmodule
